operand_fetch_ctrl: RTL and testbench
=====================================

Name: operand_fetch_ctrl

Overview:
- Read-side initiator for the 16-sector operand memory: 16 sectors x 16 words x 16-bit, two read ports, sector 15 = ROM.
- On a start command, sweeps both read ports over linear address ranges and returns word pairs (port 1, port 2) as a valid/ready stream to the MAC datapath.
- Hides memory read latency and absorbs downstream backpressure with an internal credit-controlled FIFO.

Parameters:
- READ_LATENCY, 1, clock cycles from address/sector drive to valid read_data; legal 0..2.
- FIFO_DEPTH, 4, output pair FIFO entries; power of 2, >= READ_LATENCY+1.
- DATA_W, 16, word width.

Ports:
- clock  in  1  single clock, rising edge
- reset  in  1  synchronous, active-high
- start  in  1  command strobe; accepted only in IDLE
- base_1  in  8  port-1 start linear address {sector[7:4], addr[3:0]}
- base_2  in  8  port-2 start linear address
- count  in  8  number of pairs; 0 means 256
- read_add_1, read_add_2  out  4  word address to memory
- read_sector_selector_1, read_sector_selector_2  out  4  sector select to memory
- read_data_1, read_data_2  in  DATA_W  memory read data
- out_data_1, out_data_2  out  DATA_W  fetched pair
- out_valid  out  1  pair available
- out_ready  in  1  consumer accepts
- out_last  out  1  final pair of the command, qualified by out_valid
- busy  out  1  high from start acceptance until the last pair is consumed
- done  out  1  one-cycle pulse on the cycle after the last handshake

Behaviour:
- Reset: state=IDLE; all address/sector outputs=0; out_valid=0, out_last=0, busy=0, done=0; FIFO empty; in-flight pipeline cleared. Reset mid-command aborts it; in-flight data is discarded.
- Address mapping:
  - Linear 8-bit pointer; read_sector_selector_x = ptr[7:4], read_add_x = ptr[3:0].
  - Increment by 1 per issue, mod 256; 255 wraps to 0.
- FSM: IDLE -> ISSUE on start; ISSUE -> DRAIN when the issued count reaches count; DRAIN -> IDLE when the last pair handshakes (out_valid & out_ready & out_last).
- Start acceptance: start in IDLE latches base_1, base_2 and count; busy goes high next cycle. start while busy is ignored.
- Issue rule:
  - In ISSUE, one pair issues per cycle iff in_flight + fifo_count < FIFO_DEPTH.
  - Issued data enters a READ_LATENCY-deep valid/last shift pipe, then is written to the FIFO.
  - If READ_LATENCY=0, read_data is sampled in the same cycle as the issue.
  - Pointers hold (address outputs stable) on cycles without an issue.
- Output:
  - FIFO head drives out_data_1/2, out_valid and out_last; a pop occurs on out_valid & out_ready.
  - A simultaneous push and pop when full is legal; the credit rule guarantees no overflow.
- Throughput: with out_ready held high, 1 pair/cycle sustained. First out_valid appears READ_LATENCY+1 cycles after the start cycle.
- Counters: issued/remaining counters are 9 bits so count=0 (256) is handled.
- done pulses exactly once per command. busy falls in the same cycle done rises.

Optional Feature:
- Macro: OPF_STRIDE_EN.
- Defined: adds ports stride_1 and stride_2 (in, 8), latched at start. Each pointer advances by its stride mod 256 per issue; stride 0 re-reads the same word.
- Undefined: ports absent; stride fixed at 1.

Decomposition:
- Shared package: state encoding (IDLE/ISSUE/DRAIN), ADDR_W=4, SECTOR_W=4, LIN_ADDR_W=8, ROM_SECTOR=15.
- One sub-module: opf_pair_fifo, a synchronous FIFO of 2*DATA_W+1 bits (data pair + last) with count output, FIFO_DEPTH deep.

Test Plan:
- Basic sweep, memory preloaded word(s,a)={s,a,s,a}: base_1=0x00, base_2=0x20, count=4, out_ready=1 -> pairs (0x0000,0x2020),(0x0101,0x2121),(0x0202,0x2222),(0x0303,0x2323); out_last on the 4th; done 1 cycle later; 4 consecutive valid cycles.
- Sector crossing and wrap: base_1=0xFE, base_2=0x0F, count=3 -> port1 reads sector/addr (15,14),(15,15),(0,0); port2 reads (0,15),(1,0),(1,1).
- Backpressure: count=8, out_ready low for cycles 3-10 -> issue stalls with at most FIFO_DEPTH pairs buffered, no data lost or duplicated, order preserved after release.
- count=0 -> exactly 256 pairs, out_last only on the 256th, pointer returns to base.
- start while busy ignored; reset asserted mid-DRAIN -> next cycle out_valid=0, busy=0; a fresh command afterwards completes correctly.
- OPF_STRIDE_EN: base_1=0x00, stride_1=0x10, count=3 -> port1 sectors 0,1,2 at addr 0.

Source files
------------

// File: rtl/operand_fetch_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// operand_fetch_ctrl_pkg
// Shared definitions for the operand fetch controller and its pair FIFO.
//   - Geometry of the 16-sector operand memory (sector / word address widths,
//     8-bit linear address, ROM sector index).
//   - Command widths: an 8-bit count where 0 encodes 256, widened to 9 bits.
//   - Controller FSM state encoding.
// No ports (package).
// -----------------------------------------------------------------------------
package operand_fetch_ctrl_pkg;

  localparam int ADDR_W     = 4;   // word address inside a sector
  localparam int SECTOR_W   = 4;   // sector select
  localparam int LIN_ADDR_W = 8;   // {sector, addr} linear pointer
  localparam int ROM_SECTOR = 15;  // read-only sector, read like any other
  localparam int COUNT_W    = 8;   // command pair count as presented
  localparam int PAIRS_W    = 9;   // widened so that 256 pairs is representable

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  // A count of zero means a full sweep of 256 pairs.
  function automatic logic [PAIRS_W-1:0] pairs_from_count(input logic [COUNT_W-1:0] c);
    return (c == '0) ? (PAIRS_W'(1) << COUNT_W) : {1'b0, c};
  endfunction

endpackage

// File: rtl/operand_fetch_ctrl_pair_fifo.sv
// -----------------------------------------------------------------------------
// opf_pair_fifo
// Synchronous FIFO holding fetched word pairs plus their last flag.
// Simultaneous push and pop is supported in every fill state, including full.
// Ports:
//   clock  in   rising-edge clock
//   reset  in   synchronous, active-high; empties the FIFO
//   push   in   write wdata this cycle (caller guarantees room or a same-cycle pop)
//   pop    in   drop the head entry this cycle (caller guarantees not empty)
//   wdata  in   WIDTH-bit entry
//   rdata  out  head entry (valid while empty is low)
//   count  out  current number of stored entries, 0..DEPTH
//   empty  out  no entries stored
// -----------------------------------------------------------------------------
module opf_pair_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 33
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_q, rd_q;
  logic [CNT_W-1:0] count_q;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // NOTE: storage is deliberately not reset; only the pointers and the count
  // define what is valid, so clearing the array would only cost reset fan-out.
  always_ff @(posedge clock) begin
    if (push) mem_q[wr_q] <= wdata;
  end

  // NOTE: state is updated with non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else begin
      if (push) wr_q <= ptr_inc(wr_q);
      if (pop)  rd_q <= ptr_inc(rd_q);
      case ({push, pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  assign rdata = mem_q[rd_q];
  assign count = count_q;
  assign empty = (count_q == '0);

endmodule

// File: rtl/operand_fetch_ctrl.sv
// -----------------------------------------------------------------------------
// operand_fetch_ctrl
// Read-side initiator for the 16-sector operand memory. A start command sweeps
// both read ports over linear address ranges and returns word pairs as a
// valid/ready stream. A credit rule (pairs in flight + pairs buffered must stay
// below FIFO_DEPTH) hides read latency and absorbs backpressure without loss.
// When the FIFO is empty the arriving pair is presented directly (fall-through),
// so the first pair is visible READ_LATENCY+1 cycles after the start cycle.
//
// Optional feature: define OPF_STRIDE_EN to add per-port stride inputs latched
// at start; otherwise each pointer advances by 1 per issue.
//
// Ports:
//   clock, reset                    clock; synchronous active-high reset
//   start                           command strobe, accepted only in IDLE
//   base_1, base_2                  start linear addresses {sector, addr}
//   count                           pairs to fetch, 0 means 256
//   stride_1, stride_2              (OPF_STRIDE_EN only) pointer step mod 256
//   read_add_x, read_sector_selector_x   memory address / sector per port
//   read_data_x                     memory read data, READ_LATENCY after address
//   out_data_1, out_data_2          fetched pair
//   out_valid, out_ready, out_last  output stream handshake, last pair flag
//   busy                            command in progress until last pair consumed
//   done                            one-cycle pulse after the last handshake
// -----------------------------------------------------------------------------
module operand_fetch_ctrl
  import operand_fetch_ctrl_pkg::*;
#(
  parameter int READ_LATENCY = 1,
  parameter int FIFO_DEPTH   = 4,
  parameter int DATA_W       = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [LIN_ADDR_W-1:0] base_1,
  input  logic [LIN_ADDR_W-1:0] base_2,
  input  logic [COUNT_W-1:0]    count,
`ifdef OPF_STRIDE_EN
  input  logic [LIN_ADDR_W-1:0] stride_1,
  input  logic [LIN_ADDR_W-1:0] stride_2,
`endif
  output logic [ADDR_W-1:0]     read_add_1,
  output logic [ADDR_W-1:0]     read_add_2,
  output logic [SECTOR_W-1:0]   read_sector_selector_1,
  output logic [SECTOR_W-1:0]   read_sector_selector_2,
  input  logic [DATA_W-1:0]     read_data_1,
  input  logic [DATA_W-1:0]     read_data_2,
  output logic [DATA_W-1:0]     out_data_1,
  output logic [DATA_W-1:0]     out_data_2,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_last,
  output logic                  busy,
  output logic                  done
);

  localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;
  localparam int FIFO_W = 2 * DATA_W + 1;

  state_e                state_q, state_d;
  logic [LIN_ADDR_W-1:0] ptr_1_q, ptr_2_q;
  logic [LIN_ADDR_W-1:0] step_1, step_2;
  logic [PAIRS_W-1:0]    total_q, issued_q;
  logic                  done_q;

  logic                  accept, issue, issue_last;
  logic [CNT_W-1:0]      in_flight, fifo_count;
  logic [CNT_W:0]        credit_used;
  logic                  arr_valid, arr_last;
  logic                  fifo_empty, push, pop, last_hs;
  logic [FIFO_W-1:0]     fifo_rdata;

`ifdef OPF_STRIDE_EN
  logic [LIN_ADDR_W-1:0] stride_1_q, stride_2_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      stride_1_q <= '0;
      stride_2_q <= '0;
    end else if (accept) begin
      stride_1_q <= stride_1;
      stride_2_q <= stride_2;
    end
  end

  assign step_1 = stride_1_q;
  assign step_2 = stride_2_q;
`else
  assign step_1 = LIN_ADDR_W'(1);
  assign step_2 = LIN_ADDR_W'(1);
`endif

  assign accept      = (state_q == ST_IDLE) && start;
  assign credit_used = {1'b0, in_flight} + {1'b0, fifo_count};
  assign issue       = (state_q == ST_ISSUE) && (credit_used < (CNT_W+1)'(FIFO_DEPTH));
  assign issue_last  = (issued_q + PAIRS_W'(1) == total_q);

  // Read-latency pipe: carries only valid/last; the data itself is taken from
  // read_data on the cycle the entry leaves the pipe.
  if (READ_LATENCY == 0) begin : g_no_pipe
    assign arr_valid = issue;
    assign arr_last  = issue && issue_last;
    assign in_flight = '0;
  end else begin : g_pipe
    logic [READ_LATENCY-1:0] vld_q, lst_q;

    always_ff @(posedge clock) begin
      if (reset) begin
        vld_q <= '0;
        lst_q <= '0;
      end else begin
        vld_q[0] <= issue;
        lst_q[0] <= issue && issue_last;
        for (int i = 1; i < READ_LATENCY; i++) begin
          vld_q[i] <= vld_q[i-1];
          lst_q[i] <= lst_q[i-1];
        end
      end
    end

    assign arr_valid = vld_q[READ_LATENCY-1];
    assign arr_last  = lst_q[READ_LATENCY-1];

    // NOTE: every variable written in always_comb gets a default first, so no
    // path can leave it unassigned and infer a latch.
    always_comb begin
      in_flight = '0;
      for (int i = 0; i < READ_LATENCY; i++) in_flight = in_flight + CNT_W'(vld_q[i]);
    end
  end

  // An arriving pair bypasses the FIFO only when the FIFO is empty and the
  // consumer takes it this very cycle; otherwise it is queued behind the head.
  assign push = arr_valid && !(fifo_empty && out_ready);
  assign pop  = !fifo_empty && out_ready;

  opf_pair_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (FIFO_W)
  ) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .wdata ({arr_last, read_data_1, read_data_2}),
    .rdata (fifo_rdata),
    .count (fifo_count),
    .empty (fifo_empty)
  );

  assign out_valid = !fifo_empty || arr_valid;
  assign {out_last, out_data_1, out_data_2} =
      fifo_empty ? {arr_last, read_data_1, read_data_2} : fifo_rdata;
  assign last_hs = out_valid && out_ready && out_last;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (start) state_d = ST_ISSUE;
      // With zero read latency the last pair can be consumed in its issue cycle.
      ST_ISSUE: if (last_hs)                 state_d = ST_IDLE;
                else if (issue && issue_last) state_d = ST_DRAIN;
      ST_DRAIN: if (last_hs) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      ptr_1_q  <= '0;
      ptr_2_q  <= '0;
      total_q  <= '0;
      issued_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= last_hs;
      if (accept) begin
        ptr_1_q  <= base_1;
        ptr_2_q  <= base_2;
        total_q  <= pairs_from_count(count);
        issued_q <= '0;
      end else if (issue) begin
        ptr_1_q  <= ptr_1_q + step_1;
        ptr_2_q  <= ptr_2_q + step_2;
        issued_q <= issued_q + PAIRS_W'(1);
      end
    end
  end

  assign read_sector_selector_1 = ptr_1_q[LIN_ADDR_W-1 -: SECTOR_W];
  assign read_sector_selector_2 = ptr_2_q[LIN_ADDR_W-1 -: SECTOR_W];
  assign read_add_1             = ptr_1_q[ADDR_W-1:0];
  assign read_add_2             = ptr_2_q[ADDR_W-1:0];

  assign busy = (state_q != ST_IDLE);
  assign done = done_q;

endmodule

// File: tb/tb_operand_fetch_ctrl.sv
// -----------------------------------------------------------------------------
// tb_operand_fetch_ctrl
// Self-checking bench for operand_fetch_ctrl with a one-cycle-latency memory
// model whose word at sector s, address a is {s,a,s,a}. Commands come from a
// table; each command pushes its expected pair stream into a scoreboard queue
// which is popped on every output handshake. Hand-written sequences cover
// reset in the middle of DRAIN. Compile with OPF_STRIDE_EN to add the stride row.
// -----------------------------------------------------------------------------
module tb_operand_fetch_ctrl;
  import operand_fetch_ctrl_pkg::*;

  localparam int RL    = 1;
  localparam int DEPTH = 4;
  localparam int DW    = 16;

  logic          clock = 1'b0;
  logic          reset, start, out_ready;
  logic [7:0]    base_1, base_2, count;
  logic [7:0]    stride_1, stride_2;
  logic [3:0]    read_add_1, read_add_2, read_sector_selector_1, read_sector_selector_2;
  logic [DW-1:0] read_data_1, read_data_2, out_data_1, out_data_2;
  logic          out_valid, out_last, busy, done;

  int errors = 0;
  int checks = 0;

  always #5 clock = ~clock;

  operand_fetch_ctrl #(
    .READ_LATENCY (RL),
    .FIFO_DEPTH   (DEPTH),
    .DATA_W       (DW)
  ) dut (
    .clock                  (clock),
    .reset                  (reset),
    .start                  (start),
    .base_1                 (base_1),
    .base_2                 (base_2),
    .count                  (count),
`ifdef OPF_STRIDE_EN
    .stride_1               (stride_1),
    .stride_2               (stride_2),
`endif
    .read_add_1             (read_add_1),
    .read_add_2             (read_add_2),
    .read_sector_selector_1 (read_sector_selector_1),
    .read_sector_selector_2 (read_sector_selector_2),
    .read_data_1            (read_data_1),
    .read_data_2            (read_data_2),
    .out_data_1             (out_data_1),
    .out_data_2             (out_data_2),
    .out_valid              (out_valid),
    .out_ready              (out_ready),
    .out_last               (out_last),
    .busy                   (busy),
    .done                   (done)
  );

  // Operand memory: registered read, one cycle from address to data.
  function automatic logic [DW-1:0] mem_word(input logic [3:0] s, input logic [3:0] a);
    return {s, a, s, a};
  endfunction

  always @(posedge clock) begin
    read_data_1 <= mem_word(read_sector_selector_1, read_add_1);
    read_data_2 <= mem_word(read_sector_selector_2, read_add_2);
  end

  typedef struct {
    logic [DW-1:0] d1;
    logic [DW-1:0] d2;
    logic          last;
  } pair_t;

  pair_t sb_q[$];

  typedef struct {
    logic [7:0]    b1, b2, cnt, s1, s2;
    int            stall_from, stall_to;  // out_ready low for these cycles (inclusive)
    int            spurious_k;            // cycle of an extra start while busy, 0 = none
    logic [DW-1:0] first1, first2;        // expected first pair
    logic [7:0]    end1;                  // expected port-1 pointer after completion
    int            n;                     // expected number of pairs
  } vec_t;

  vec_t vecs[6];
  int   nvec;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Runs one table command; cycle k = 0 is the start cycle.
  task automatic run_cmd(input int idx);
    vec_t       v;
    int         k, first_k, last_k, done_k, done_cnt, hs, issues, outstanding, max_out;
    logic [7:0] p1, p2, prev_ptr, ptr_now;
    pair_t      e;
    v = vecs[idx];
    for (int i = 0; i < v.n; i++) begin
      p1 = v.b1 + 8'(i) * v.s1;
      p2 = v.b2 + 8'(i) * v.s2;
      sb_q.push_back('{d1: {p1, p1}, d2: {p2, p2}, last: (i == v.n - 1)});
    end
    first_k = -1; last_k = -1; done_k = -1; done_cnt = 0;
    hs = 0; issues = 0; max_out = 0; prev_ptr = '0;
    k = 0;
    @(posedge clock); #1;
    start = 1'b1; base_1 = v.b1; base_2 = v.b2; count = v.cnt;
    stride_1 = v.s1; stride_2 = v.s2; out_ready = 1'b1;
    forever begin
      @(negedge clock);
      ptr_now = {read_sector_selector_1, read_add_1};
      if (k == 1) begin
        check($sformatf("row%0d_busy_after_start", idx), busy, 1'b1);
        check($sformatf("row%0d_first_addr1", idx), ptr_now, v.b1);
        check($sformatf("row%0d_first_addr2", idx),
              {read_sector_selector_2, read_add_2}, v.b2);
      end
      if (k >= 2 && ptr_now != prev_ptr) issues++;
      if (k >= 1) prev_ptr = ptr_now;
      outstanding = issues - hs;
      if (outstanding > max_out) max_out = outstanding;
      if (out_valid && first_k < 0) first_k = k;
      if (out_valid && out_ready) begin
        if (hs == 0) begin
          check($sformatf("row%0d_first_d1", idx), out_data_1, v.first1);
          check($sformatf("row%0d_first_d2", idx), out_data_2, v.first2);
        end
        if (sb_q.size() == 0) begin
          check($sformatf("row%0d_extra_pair", idx), hs, v.n);
        end else begin
          e = sb_q.pop_front();
          check($sformatf("row%0d_pair%0d_d1", idx, hs), out_data_1, e.d1);
          check($sformatf("row%0d_pair%0d_d2", idx, hs), out_data_2, e.d2);
          check($sformatf("row%0d_pair%0d_last", idx, hs), out_last, e.last);
        end
        if (out_last) last_k = k;
        hs++;
      end
      if (done) begin
        done_cnt++;
        if (done_k < 0) begin
          done_k = k;
          check($sformatf("row%0d_busy_at_done", idx), busy, 1'b0);
        end
      end
      if (done_k >= 0 && k == done_k + 1) break;
      if (k >= 2000) begin
        check($sformatf("row%0d_timeout_done_seen", idx), 0, 1);
        break;
      end
      @(posedge clock); #1;
      k++;
      start = (v.spurious_k > 0 && k == v.spurious_k);
      if (start) begin
        base_1 = 8'hC3; base_2 = 8'h3C; count = 8'd1;
      end
      out_ready = !(k >= v.stall_from && k <= v.stall_to);
    end
    start     = 1'b0;
    out_ready = 1'b1;
    check($sformatf("row%0d_first_valid_cycle", idx), first_k, RL + 1);
    check($sformatf("row%0d_pairs", idx), hs, v.n);
    check($sformatf("row%0d_issues", idx), issues, v.n);
    check($sformatf("row%0d_done_after_last", idx), done_k, last_k + 1);
    check($sformatf("row%0d_done_pulses", idx), done_cnt, 1);
    check($sformatf("row%0d_sb_empty", idx), sb_q.size(), 0);
    check($sformatf("row%0d_buffered_within_depth", idx), (max_out <= DEPTH), 1'b1);
    check($sformatf("row%0d_end_ptr1", idx), {read_sector_selector_1, read_add_1}, v.end1);
    sb_q.delete();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vecs[0] = '{b1: 8'h00, b2: 8'h20, cnt: 8'd4, s1: 8'd1, s2: 8'd1, stall_from: 9999, stall_to: 9999,
                spurious_k: 0, first1: 16'h0000, first2: 16'h2020, end1: 8'h04, n: 4};
    vecs[1] = '{b1: 8'hFE, b2: 8'h0F, cnt: 8'd3, s1: 8'd1, s2: 8'd1, stall_from: 9999, stall_to: 9999,
                spurious_k: 0, first1: 16'hFEFE, first2: 16'h0F0F, end1: 8'h01, n: 3};
    vecs[2] = '{b1: 8'h10, b2: 8'h30, cnt: 8'd8, s1: 8'd1, s2: 8'd1, stall_from: 3, stall_to: 10,
                spurious_k: 0, first1: 16'h1010, first2: 16'h3030, end1: 8'h18, n: 8};
    vecs[3] = '{b1: 8'h40, b2: 8'h80, cnt: 8'd0, s1: 8'd1, s2: 8'd1, stall_from: 9999, stall_to: 9999,
                spurious_k: 0, first1: 16'h4040, first2: 16'h8080, end1: 8'h40, n: 256};
    vecs[4] = '{b1: 8'h05, b2: 8'hA0, cnt: 8'd6, s1: 8'd1, s2: 8'd1, stall_from: 9999, stall_to: 9999,
                spurious_k: 2, first1: 16'h0505, first2: 16'hA0A0, end1: 8'h0B, n: 6};
    vecs[5] = '{b1: 8'h00, b2: 8'h05, cnt: 8'd3, s1: 8'h10, s2: 8'h00, stall_from: 9999, stall_to: 9999,
                spurious_k: 0, first1: 16'h0000, first2: 16'h0505, end1: 8'h30, n: 3};
`ifdef OPF_STRIDE_EN
    nvec = 6;
`else
    nvec = 5;
`endif

    reset = 1'b1; start = 1'b0; out_ready = 1'b1;
    base_1 = '0; base_2 = '0; count = '0; stride_1 = 8'd1; stride_2 = 8'd1;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    check("reset_out_valid", out_valid, 1'b0);
    check("reset_out_last", out_last, 1'b0);
    check("reset_busy", busy, 1'b0);
    check("reset_done", done, 1'b0);
    check("reset_addr1", {read_sector_selector_1, read_add_1}, 8'h00);
    check("reset_addr2", {read_sector_selector_2, read_add_2}, 8'h00);

    for (int r = 0; r < nvec; r++) run_cmd(r);

    // Reset while DRAIN holds buffered pairs behind a stalled consumer.
    @(posedge clock); #1;
    start = 1'b1; base_1 = 8'h50; base_2 = 8'h60; count = 8'd3; out_ready = 1'b0;
    @(posedge clock); #1;
    start = 1'b0;
    repeat (5) @(posedge clock);
    @(negedge clock);
    check("drain_out_valid", out_valid, 1'b1);
    check("drain_head_d1", out_data_1, 16'h5050);
    check("drain_busy", busy, 1'b1);
    @(posedge clock); #1;
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    @(negedge clock);
    check("abort_out_valid", out_valid, 1'b0);
    check("abort_busy", busy, 1'b0);
    check("abort_done", done, 1'b0);
    check("abort_addr1", {read_sector_selector_1, read_add_1}, 8'h00);
    out_ready = 1'b1;
    repeat (2) @(posedge clock);
    @(negedge clock);
    check("abort_no_stale_valid", out_valid, 1'b0);

    run_cmd(0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
